// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;
  typedef enum logic {OpRd, OpWr} op_e;

  localparam int unsigned HW_BYTES   = 2;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/half_ram.sv
// Halfword-wide single-port RAM: synchronous write, asynchronous read.
module half_ram
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_HW  = 1024,
  parameter string       INIT_FILE = ""
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic [$clog2(DEPTH_HW)-1:0] idx_i,
  input  logic [DATA_W-1:0]           wdata_i,
  output logic [DATA_W-1:0]           rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_HW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: request FSM with wait states, address checking and
// low/high read-pair reassembly into a 32-bit word.
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_HW    = 1024,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  output logic              mem_ready_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rvalid_o,
  output logic              mem_wack_o,
  output logic              mem_err_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_HW);
  localparam int unsigned OffW = IdxW + 1;
  localparam logic [ADDR_W-1:0] SpanBytes = ADDR_W'(HW_BYTES * DEPTH_HW);
  localparam logic [WAIT_CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] req_off;
  logic              req_err, accept;

  op_e               op_q;
  logic              err_q;
  logic [OffW-1:0]   off_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] ram_rdata;
  logic              in_resp, rd_ok, wr_ok, ram_we, pair_hit;

  logic              pending_q;
  logic [OffW-1:0]   pair_off_q;
  logic [DATA_W-1:0] low_q;
  logic [WORD_W-1:0] word_q;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign req_off = mem_addr_i - BASE_ADDR;
  assign req_err = mem_addr_i[0] | (req_off >= SpanBytes) | (mem_re_i & mem_we_i);
  assign accept  = (state_q == StIdle) & (mem_re_i | mem_we_i);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= OpRd;
      err_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= mem_we_i ? OpWr : OpRd;
      err_q   <= req_err;
      off_q   <= req_off[OffW-1:0];
      wdata_q <= mem_wdata_i;
    end
  end

  assign in_resp  = (state_q == StResp);
  assign rd_ok    = in_resp & ~err_q & (op_q == OpRd);
  assign wr_ok    = in_resp & ~err_q & (op_q == OpWr);
  // A reset landing on the response edge must not commit the write.
  assign ram_we   = wr_ok & ~rst_i;
  assign pair_hit = rd_ok & pending_q & (off_q == pair_off_q + OffW'(HW_BYTES));

  half_ram #(
    .DEPTH_HW  (DEPTH_HW),
    .INIT_FILE (INIT_FILE)
  ) u_half_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .idx_i   (off_q[OffW-1:1]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q  <= 1'b0;
      pair_off_q <= '0;
      low_q      <= '0;
      word_q     <= '0;
    end else if (in_resp) begin
      if (pair_hit) begin
        word_q    <= {ram_rdata, low_q};
        pending_q <= 1'b0;
      end else if (rd_ok && !off_q[1]) begin
        pending_q  <= 1'b1;
        low_q      <= ram_rdata;
        pair_off_q <= off_q;
      end else begin
        pending_q <= 1'b0;
      end
    end
  end

  assign mem_ready_o  = (state_q == StIdle);
  assign mem_rvalid_o = rd_ok;
  assign mem_rdata_o  = rd_ok ? ram_rdata : '0;
  assign mem_wack_o   = wr_ok;
  assign mem_err_o    = in_resp & err_q;
  assign word_valid_o = pair_hit;
  assign word_o       = pair_hit ? {ram_rdata, low_q} : word_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders with 0, 3 and 2 wait states share one clock.
module tb_data_mem_responder;

  logic        clk;
  logic        rst    [3];
  logic [31:0] addr   [3];
  logic [15:0] wdata  [3];
  logic        re     [3];
  logic        we     [3];
  logic        ready  [3];
  logic [15:0] rdata  [3];
  logic        rvalid [3];
  logic        wack   [3];
  logic        err    [3];
  logic [31:0] word   [3];
  logic        wvalid [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    data_mem_responder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_HW    (64),
      .WAIT_CYCLES (W),
      .INIT_FILE   ("")
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst[g]),
      .mem_addr_i   (addr[g]),
      .mem_wdata_i  (wdata[g]),
      .mem_re_i     (re[g]),
      .mem_we_i     (we[g]),
      .mem_ready_o  (ready[g]),
      .mem_rdata_o  (rdata[g]),
      .mem_rvalid_o (rvalid[g]),
      .mem_wack_o   (wack[g]),
      .mem_err_o    (err[g]),
      .word_o       (word[g]),
      .word_valid_o (wvalid[g])
    );
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Presents a request for one accept edge; returns in the cycle after that edge.
  task automatic req(input int i, input logic r, input logic w,
                     input logic [31:0] a, input logic [15:0] d);
    re[i] = r; we[i] = w; addr[i] = a; wdata[i] = d;
    step(1);
    re[i] = 1'b0; we[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; addr[i] = '0; wdata[i] = '0; re[i] = 1'b0; we[i] = 1'b0;
    end
    step(2);
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_rvalid", 32'(rvalid[0]), 32'd0);
    check("rst_wack", 32'(wack[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_word", word[0], 32'h0);
    check("rst_wvalid", 32'(wvalid[0]), 32'd0);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    step(1);

    // 1: zero wait states
    req(0, 1'b0, 1'b1, 32'h10, 16'h1234);
    check("t1_wack", 32'(wack[0]), 32'd1);
    check("t1_wr_ready", 32'(ready[0]), 32'd0);
    check("t1_wr_rvalid", 32'(rvalid[0]), 32'd0);
    step(1);
    check("t1_wack_pulse", 32'(wack[0]), 32'd0);
    check("t1_ready_back", 32'(ready[0]), 32'd1);
    req(0, 1'b1, 1'b0, 32'h10, 16'h0);
    check("t1_rvalid", 32'(rvalid[0]), 32'd1);
    check("t1_rdata", 32'(rdata[0]), 32'h1234);
    step(1);
    check("t1_rvalid_pulse", 32'(rvalid[0]), 32'd0);

    // 2: three wait states, inputs wiggled during WAIT
    req(1, 1'b0, 1'b1, 32'h0, 16'h5A5A);
    for (int k = 0; k < 4; k++) begin
      check("t2_wr_ready", 32'(ready[1]), 32'd0);
      check("t2_wack", 32'(wack[1]), (k == 3) ? 32'd1 : 32'd0);
      step(1);
    end
    check("t2_ready_idle", 32'(ready[1]), 32'd1);
    req(1, 1'b1, 1'b0, 32'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin addr[1] = 32'h33; re[1] = 1'b1; we[1] = 1'b1; wdata[1] = 16'hFFFF; end
      if (k == 2) begin re[1] = 1'b0; we[1] = 1'b0; end
      check("t2_rd_ready", 32'(ready[1]), 32'd0);
      check("t2_rvalid", 32'(rvalid[1]), (k == 3) ? 32'd1 : 32'd0);
      check("t2_err", 32'(err[1]), 32'd0);
      if (k == 3) check("t2_rdata", 32'(rdata[1]), 32'h5A5A);
      step(1);
    end
    check("t2_ready_after", 32'(ready[1]), 32'd1);
    check("t2_rvalid_after", 32'(rvalid[1]), 32'd0);

    // 3: pair reassembly
    req(0, 1'b0, 1'b1, 32'h20, 16'hBEEF); step(1);
    req(0, 1'b0, 1'b1, 32'h22, 16'hDEAD); step(1);
    req(0, 1'b1, 1'b0, 32'h20, 16'h0);
    check("t3_lo_rdata", 32'(rdata[0]), 32'hBEEF);
    check("t3_lo_wvalid", 32'(wvalid[0]), 32'd0);
    step(1);
    req(0, 1'b1, 1'b0, 32'h22, 16'h0);
    check("t3_hi_rdata", 32'(rdata[0]), 32'hDEAD);
    check("t3_wvalid", 32'(wvalid[0]), 32'd1);
    check("t3_word", word[0], 32'hDEADBEEF);
    step(1);
    check("t3_wvalid_pulse", 32'(wvalid[0]), 32'd0);
    check("t3_word_hold", word[0], 32'hDEADBEEF);

    // 4: error cases
    req(0, 1'b1, 1'b0, 32'h21, 16'h0);
    check("t4_misal_err", 32'(err[0]), 32'd1);
    check("t4_misal_rvalid", 32'(rvalid[0]), 32'd0);
    check("t4_misal_rdata", 32'(rdata[0]), 32'h0);
    step(1);
    check("t4_err_pulse", 32'(err[0]), 32'd0);
    req(0, 1'b1, 1'b0, 32'h80, 16'h0);
    check("t4_range_err", 32'(err[0]), 32'd1);
    check("t4_range_rvalid", 32'(rvalid[0]), 32'd0);
    step(1);
    req(0, 1'b1, 1'b1, 32'h20, 16'hFFFF);
    check("t4_both_err", 32'(err[0]), 32'd1);
    check("t4_both_wack", 32'(wack[0]), 32'd0);
    check("t4_both_rvalid", 32'(rvalid[0]), 32'd0);
    step(1);
    req(0, 1'b0, 1'b1, 32'h0, 16'h7777); step(1);
    req(0, 1'b0, 1'b1, 32'h80, 16'h1111);
    check("t4_oor_wr_err", 32'(err[0]), 32'd1);
    check("t4_oor_wr_wack", 32'(wack[0]), 32'd0);
    step(1);
    req(0, 1'b1, 1'b0, 32'h0, 16'h0);
    check("t4_no_alias", 32'(rdata[0]), 32'h7777);
    step(1);
    req(0, 1'b1, 1'b0, 32'h20, 16'h0);
    check("t4_unchanged", 32'(rdata[0]), 32'hBEEF);
    step(1);
    req(0, 1'b1, 1'b0, 32'h21, 16'h0); step(1);
    req(0, 1'b1, 1'b0, 32'h22, 16'h0);
    check("t4_err_clears", 32'(wvalid[0]), 32'd0);
    check("t4_hi_rvalid", 32'(rvalid[0]), 32'd1);
    step(1);

    // 5: intervening write breaks the pair
    req(0, 1'b1, 1'b0, 32'h20, 16'h0); step(1);
    req(0, 1'b0, 1'b1, 32'h30, 16'h3030); step(1);
    req(0, 1'b1, 1'b0, 32'h22, 16'h0);
    check("t5_wvalid", 32'(wvalid[0]), 32'd0);
    check("t5_rdata", 32'(rdata[0]), 32'hDEAD);
    check("t5_word_hold", word[0], 32'hDEADBEEF);
    step(1);

    // 6: reset during WAIT aborts the write
    req(2, 1'b0, 1'b1, 32'h40, 16'hAAAA);
    step(2);
    check("t6_first_wack", 32'(wack[2]), 32'd1);
    step(1);
    req(2, 1'b0, 1'b1, 32'h40, 16'h5555);
    check("t6_in_wait", 32'(ready[2]), 32'd0);
    rst[2] = 1'b1;
    step(1);
    rst[2] = 1'b0;
    check("t6_rst_ready", 32'(ready[2]), 32'd1);
    check("t6_rst_wack", 32'(wack[2]), 32'd0);
    check("t6_rst_err", 32'(err[2]), 32'd0);
    check("t6_rst_word", word[2], 32'h0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("t6_no_wack", 32'(wack[2]), 32'd0);
    end
    req(2, 1'b1, 1'b0, 32'h40, 16'h0);
    step(2);
    check("t6_rvalid", 32'(rvalid[2]), 32'd1);
    check("t6_mem_kept", 32'(rdata[2]), 32'hAAAA);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
